// File: rtl/axis_fifo_serializer.sv
// axis_fifo_serializer
// Pops DWIDTH-bit words from a sync FIFO read port (one cycle read latency)
// and emits each word as RATIO = DWIDTH/OWIDTH AXI-Stream beats. tlast marks
// the final beat of every word. At most one FIFO word is in flight.
//
// Build option: define SER_MSB_FIRST_EN to issue the most-significant slice
// first. The default build (macro undefined) issues the LSB slice first.
`timescale 1ns/1ps

module axis_fifo_serializer #(
  parameter int DWIDTH = 16,
  parameter int OWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [OWIDTH-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready
);

  localparam int RATIO = DWIDTH / OWIDTH;
  localparam int CW    = $clog2(RATIO);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] SEND = 2'd2;

  localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [DWIDTH-1:0] shreg;
  logic [CW-1:0]     sel;
  logic              last_beat;
  logic              handshake;

  assign last_beat = (cnt == LAST_CNT);
  assign handshake = m_axis_tvalid & m_axis_tready;

`ifdef SER_MSB_FIRST_EN
  assign sel = LAST_CNT - cnt;
`else
  assign sel = cnt;
`endif

  // Beat outputs decoded from registered state; rd_en also looks at empty/tready.
  // NOTE: every signal assigned in always_comb gets a default first, otherwise a
  // path that skips the assignment infers a latch.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    fifo_rd_en    = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: fifo_rd_en = !fifo_empty;
        SEND: begin
          m_axis_tvalid = 1'b1;
          m_axis_tlast  = last_beat;
          m_axis_tdata  = shreg[int'(sel)*OWIDTH +: OWIDTH];
          fifo_rd_en    = m_axis_tready & last_beat & !fifo_empty;
        end
        default: ;
      endcase
    end
  end

  // State, beat counter and word register; reset drops any partial word.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        IDLE: if (fifo_rd_en) state <= WAIT;
        WAIT: begin
          shreg <= fifo_dout;
          cnt   <= '0;
          state <= SEND;
        end
        SEND: begin
          if (handshake) begin
            if (!last_beat) begin
              cnt <= cnt + 1'b1;
            end else begin
              cnt   <= '0;
              state <= fifo_rd_en ? WAIT : IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_fifo_serializer.sv
// Directed bench for axis_fifo_serializer (DWIDTH=16, OWIDTH=4).
// A small behavioural FIFO with one-cycle read latency feeds the DUT.
// Define SER_MSB_FIRST_EN for both files to exercise the MSB-first build.
`timescale 1ns/1ps

module tb_axis_fifo_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] fifo_dout = '0;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [3:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b1;

  logic [15:0] mem [0:15];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  int checks = 0;
  int errors = 0;

  axis_fifo_serializer #(.DWIDTH(16), .OWIDTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_dout     (fifo_dout),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: registered read data, valid the cycle after a pop.
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_dout <= mem[rd_ptr % 16];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [15:0] w);
    mem[wr_ptr % 16] = w;
    wr_ptr++;
  endtask

  // k-th beat of a word in issue order.
  function automatic logic [3:0] beat(input logic [15:0] w, input int k);
    logic [15:0] t;
    t = w;
`ifdef SER_MSB_FIRST_EN
    return t[(3-k)*4 +: 4];
`else
    return t[k*4 +: 4];
`endif
  endfunction

  // Entered with the first beat on the bus (tready = 1); leaves one cycle after
  // the last beat. 'more' says whether another word is queued behind this one.
  task automatic expect_word(input string tag, input logic [15:0] w, input bit more);
    for (int k = 0; k < 4; k++) begin
      check({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd1);
      check({tag, "_tdata"},  32'(m_axis_tdata),  32'(beat(w, k)));
      check({tag, "_tlast"},  32'(m_axis_tlast),  32'(k == 3));
      check({tag, "_rd_en"},  32'(fifo_rd_en),    32'(more && k == 3));
      @(negedge clk); #1;
    end
  endtask

  task automatic check_idle(input string tag, input bit rd_exp);
    check({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    check({tag, "_tlast"},  32'(m_axis_tlast),  32'd0);
    check({tag, "_tdata"},  32'(m_axis_tdata),  32'd0);
    check({tag, "_rd_en"},  32'(fifo_rd_en),    32'(rd_exp));
  endtask

  initial begin
    // Reset state.
    rst = 1'b1;
    @(negedge clk); #1;
    check_idle("reset", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle("post_reset", 1'b0);

    // Empty FIFO throughout: no pop, no beat.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("empty_rd_en",  32'(fifo_rd_en),    32'd0);
      check("empty_tvalid", 32'(m_axis_tvalid), 32'd0);
    end

    // Late push of a single word: pop on the first non-empty cycle.
    @(negedge clk);
    push(16'hABCD);
    #1;
    check("single_pop", 32'(fifo_rd_en), 32'd1);
    check("single_pop_tvalid", 32'(m_axis_tvalid), 32'd0);
    @(negedge clk); #1;
    check_idle("single_wait", 1'b0);
    @(negedge clk); #1;
    expect_word("single", 16'hABCD, 1'b0);
    check_idle("single_done", 1'b0);

    // Back-to-back words: one WAIT bubble between them.
    @(negedge clk);
    push(16'h1234);
    push(16'h5678);
    #1;
    check("b2b_pop", 32'(fifo_rd_en), 32'd1);
    @(negedge clk); #1;
    check_idle("b2b_wait0", 1'b0);
    @(negedge clk); #1;
    expect_word("b2b_w0", 16'h1234, 1'b1);
    check_idle("b2b_bubble", 1'b0);
    @(negedge clk); #1;
    expect_word("b2b_w1", 16'h5678, 1'b0);
    check_idle("b2b_done", 1'b0);

    // Backpressure on the second beat for three cycles.
    @(negedge clk);
    push(16'hABCD);
    #1;
    check("bp_pop", 32'(fifo_rd_en), 32'd1);
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("bp_beat0", 32'(m_axis_tdata), 32'(beat(16'hABCD, 0)));
    @(negedge clk);
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_hold_tdata",  32'(m_axis_tdata),  32'(beat(16'hABCD, 1)));
      check("bp_hold_tvalid", 32'(m_axis_tvalid), 32'd1);
      check("bp_hold_tlast",  32'(m_axis_tlast),  32'd0);
      @(negedge clk);
    end
    m_axis_tready = 1'b1;
    #1;
    check("bp_release", 32'(m_axis_tdata), 32'(beat(16'hABCD, 1)));
    @(negedge clk); #1;
    check("bp_beat2",  32'(m_axis_tdata), 32'(beat(16'hABCD, 2)));
    check("bp_tlast2", 32'(m_axis_tlast), 32'd0);
    @(negedge clk); #1;
    check("bp_beat3",  32'(m_axis_tdata), 32'(beat(16'hABCD, 3)));
    check("bp_tlast3", 32'(m_axis_tlast), 32'd1);
    @(negedge clk); #1;
    check_idle("bp_done", 1'b0);

    // Reset mid-word: the rest of 0xABCD is dropped, 0x9876 follows intact.
    @(negedge clk);
    push(16'hABCD);
    push(16'h9876);
    #1;
    check("rst_pop", 32'(fifo_rd_en), 32'd1);
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("rst_beat0", 32'(m_axis_tdata), 32'(beat(16'hABCD, 0)));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle("rst_active", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle("rst_after", 1'b1);
    @(negedge clk); #1;
    check_idle("rst_wait", 1'b0);
    @(negedge clk); #1;
    expect_word("rst_next", 16'h9876, 1'b0);
    check_idle("rst_done", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
